// File: rtl/dcache_pkg.sv
// dcache_pkg: shared FSM/write-source types and way-index/PLRU helpers for the dcache tag array
package dcache_pkg;
    typedef enum logic {INIT, READY} state_e;
    typedef enum logic [1:0] {SRC_NONE, SRC_L2, SRC_MEM, SRC_CORE} wsrc_e;
    localparam int MAX_WAYS = 8;
    localparam int TW = MAX_WAYS - 1;
    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction
    function automatic logic [2:0] oh2idx(input logic [MAX_WAYS-1:0] oh);
        logic [2:0] r;
        r = '0;
        for (int i = MAX_WAYS - 1; i >= 0; i--) if (oh[i]) r = 3'(i);
        return r;
    endfunction
    // Heap-ordered tree: node n has children 2n/2n+1, bit n-1 set means the victim lies right
    function automatic logic [TW-1:0] plru_touch(input logic [TW-1:0] t, input logic [2:0] way, input int lg);
        logic [TW-1:0] r;
        logic d;
        int n;
        r = t;
        n = 1;
        for (int l = 0; l < 3; l++) if (l < lg) begin
            d = way[2'(lg - 1 - l)];
            r[3'(n - 1)] = ~d;
            n = 2 * n + int'(d);
        end
        return r;
    endfunction
    function automatic logic [2:0] plru_victim(input logic [TW-1:0] t, input int lg);
        int n;
        n = 1;
        for (int l = 0; l < 3; l++) if (l < lg) n = 2 * n + int'(t[3'(n - 1)]);
        return 3'(n - (1 << lg));
    endfunction
endpackage

// File: rtl/dtag_repl.sv
// dtag_repl: per-set replacement state with touch/victim logic
// DTAG_PLRU_EN selects tree pseudo-LRU; otherwise a refill-advanced round-robin pointer.
module dtag_repl import dcache_pkg::*; #(
    parameter int WAYS = 2,
    parameter int SETS = 256,
    localparam int IDX_W = idx_w(SETS),
    localparam int LW = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [IDX_W-1:0] clr_idx,
    input  logic             wr_en,
    input  logic             wr_refill,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [LW-1:0]    wr_way,
    input  logic             hit_en,
    input  logic [IDX_W-1:0] hit_idx,
    input  logic [LW-1:0]    hit_way,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [WAYS-1:0]  victim
);
`ifdef DTAG_PLRU_EN
    logic [WAYS-2:0] st [SETS];
    logic unused_plru;
    assign unused_plru = wr_refill;
    // Write touch is issued last so it wins when both land on the same set
    always_ff @(posedge clk)
        if (clr) st[clr_idx] <= '0;
        else begin
            if (hit_en) st[hit_idx] <= (WAYS-1)'(plru_touch(TW'(st[hit_idx]), 3'(hit_way), LW));
            if (wr_en) st[wr_idx] <= (WAYS-1)'(plru_touch(TW'(st[wr_idx]), 3'(wr_way), LW));
        end
    assign victim = WAYS'(1) << plru_victim(TW'(st[rd_idx]), LW);
`else
    logic [LW-1:0] ptr [SETS];
    logic unused_rr;
    assign unused_rr = ^{wr_way, hit_en, hit_idx, hit_way};
    always_ff @(posedge clk)
        if (clr) ptr[clr_idx] <= '0;
        else if (wr_en && wr_refill) ptr[wr_idx] <= ptr[wr_idx] + LW'(1);
    assign victim = WAYS'(1) << ptr[rd_idx];
`endif
endmodule

// File: rtl/dtag_array_nway.sv
// dtag_array_nway: N-way dcache tag/state array with refill/store arbitration and one lookup port
// Replacement policy chosen by DTAG_PLRU_EN (tree PLRU) or round-robin when undefined.
module dtag_array_nway import dcache_pkg::*; #(
    parameter int WAYS = 2,
    parameter int SETS = 256,
    parameter int TAG_W = 21,
    parameter int THREAD_W = 2,
    localparam int IDX_W = idx_w(SETS)
) (
    input  logic                clk,
    input  logic                rst,
    output logic                init_busy,
    input  logic                rd_en,
    input  logic [IDX_W-1:0]    rd_index,
    input  logic [TAG_W-1:0]    rd_tag,
    input  logic [THREAD_W-1:0] rd_thread,
    output logic                rd_valid,
    output logic                hit,
    output logic [WAYS-1:0]     hit_way,
    output logic [WAYS-1:0]     victim_way,
    output logic [TAG_W-1:0]    victim_tag,
    output logic                victim_dirty,
    output logic [THREAD_W-1:0] victim_thread,
    input  logic                l2_we,
    input  logic [IDX_W-1:0]    l2_index,
    input  logic [WAYS-1:0]     l2_way,
    input  logic [TAG_W-1:0]    l2_tag,
    input  logic [THREAD_W-1:0] l2_thread,
    input  logic                mem_we,
    input  logic [IDX_W-1:0]    mem_index,
    input  logic [WAYS-1:0]     mem_way,
    input  logic [TAG_W-1:0]    mem_tag,
    input  logic [THREAD_W-1:0] mem_thread,
    input  logic                core_we,
    input  logic [IDX_W-1:0]    core_index,
    input  logic [WAYS-1:0]     core_way,
    output logic                core_ready
);
    localparam int LW = $clog2(WAYS);
    state_e state, state_n;
    wsrc_e src;
    logic [IDX_W-1:0] cnt, cnt_n, w_idx, rd_idx_q;
    logic [WAYS-1:0] w_way, v_new, d_new, valid_q, dirty_q, vict_q, repl_victim, match, inv;
    logic [TAG_W-1:0] w_tag, rd_tag_q;
    logic [THREAD_W-1:0] w_thr, rd_thr_q;
    logic ready, rd_fire, w_refill, w_ok, byp, have;
    logic [WAYS-1:0] valid [SETS];
    logic [WAYS-1:0] dirty [SETS];
    logic [TAG_W-1:0] tag_mem [WAYS][SETS];
    logic [THREAD_W-1:0] thr_mem [WAYS][SETS];
    logic [TAG_W-1:0] tag_q [WAYS];
    logic [THREAD_W-1:0] thr_q [WAYS];

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= INIT;
            cnt <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
        end
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        if (state == INIT) begin
            cnt_n = cnt + 1'b1;
            if (cnt == IDX_W'(SETS - 1)) state_n = READY;
        end
    end
    assign ready = state == READY;
    assign init_busy = state == INIT;
    assign rd_fire = rd_en && ready;
    assign src = !ready ? SRC_NONE : l2_we ? SRC_L2 : mem_we ? SRC_MEM : core_we ? SRC_CORE : SRC_NONE;
    assign w_idx = src == SRC_L2 ? l2_index : src == SRC_MEM ? mem_index : core_index;
    assign w_way = src == SRC_L2 ? l2_way : src == SRC_MEM ? mem_way : core_way;
    assign w_tag = src == SRC_L2 ? l2_tag : mem_tag;
    assign w_thr = src == SRC_L2 ? l2_thread : mem_thread;
    assign w_refill = src == SRC_L2 || src == SRC_MEM;
    assign w_ok = src != SRC_NONE && $onehot(w_way);
    assign core_ready = src == SRC_CORE;
    assign v_new = w_refill ? valid[w_idx] | w_way : valid[w_idx];
    assign d_new = w_refill ? dirty[w_idx] & ~w_way : dirty[w_idx] | w_way;
    assign byp = w_ok && w_idx == rd_index;

    // Sweep owns the state flops while INIT; no writes can win then
    always_ff @(posedge clk)
        if (!ready) begin
            valid[cnt] <= '0;
            dirty[cnt] <= '0;
        end else if (w_ok) begin
            valid[w_idx] <= v_new;
            dirty[w_idx] <= d_new;
        end
    always_ff @(posedge clk)
        for (int i = 0; i < WAYS; i++) begin
            if (w_ok && w_refill && w_way[i]) begin
                tag_mem[i][w_idx] <= w_tag;
                thr_mem[i][w_idx] <= w_thr;
            end
            if (rd_fire) begin
                tag_q[i] <= (byp && w_refill && w_way[i]) ? w_tag : tag_mem[i][rd_index];
                thr_q[i] <= (byp && w_refill && w_way[i]) ? w_thr : thr_mem[i][rd_index];
            end
        end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rd_valid <= 1'b0;
            have <= 1'b0;
            rd_idx_q <= '0;
            rd_tag_q <= '0;
            rd_thr_q <= '0;
            valid_q <= '0;
            dirty_q <= '0;
            vict_q <= '0;
        end else begin
            rd_valid <= rd_fire;
            if (rd_fire) begin
                have <= 1'b1;
                rd_idx_q <= rd_index;
                rd_tag_q <= rd_tag;
                rd_thr_q <= rd_thread;
                valid_q <= byp ? v_new : valid[rd_index];
                dirty_q <= byp ? d_new : dirty[rd_index];
                vict_q <= repl_victim;
            end
        end

    always_comb begin
        match = '0;
        for (int i = 0; i < WAYS; i++) match[i] = valid_q[i] && tag_q[i] == rd_tag_q && thr_q[i] == rd_thr_q;
    end
    assign inv = ~valid_q;
    assign hit_way = have ? match & (~match + 1'b1) : '0;
    assign hit = |hit_way;
    assign victim_way = !have ? '0 : |inv ? inv & (~inv + 1'b1) : vict_q;
    assign victim_dirty = |(victim_way & valid_q & dirty_q);
    always_comb begin
        victim_tag = '0;
        victim_thread = '0;
        for (int i = 0; i < WAYS; i++) if (victim_way[i]) begin
            victim_tag = tag_q[i];
            victim_thread = thr_q[i];
        end
    end

    dtag_repl #(.WAYS(WAYS), .SETS(SETS)) u_repl (
        .clk       (clk),
        .clr       (!ready),
        .clr_idx   (cnt),
        .wr_en     (w_ok),
        .wr_refill (w_refill),
        .wr_idx    (w_idx),
        .wr_way    (LW'(oh2idx(MAX_WAYS'(w_way)))),
        .hit_en    (rd_valid && hit),
        .hit_idx   (rd_idx_q),
        .hit_way   (LW'(oh2idx(MAX_WAYS'(hit_way)))),
        .rd_idx    (rd_index),
        .victim    (repl_victim)
    );

    always @(posedge clk)
        if (!rst) begin
            assert (!(ready && l2_we && mem_we));
            assert (src == SRC_NONE || $onehot(w_way));
            assert (!rd_valid || $onehot0(match));
        end
endmodule

// File: tb/tb_dtag_array_nway.sv
// tb_dtag_array_nway: directed self-checking bench for the N-way tag array (2-way and 4-way instances)
module tb_dtag_array_nway;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic rd_en, l2_we, mem_we, core_we;
    logic [7:0] rd_index, l2_index, mem_index, core_index;
    logic [20:0] rd_tag, l2_tag, mem_tag;
    logic [1:0] rd_thread, l2_thread, mem_thread, l2_way, mem_way, core_way;
    logic init_busy, rd_valid, hit, victim_dirty, core_ready;
    logic [1:0] hit_way, victim_way, victim_thread;
    logic [20:0] victim_tag;

    logic f_rd_en, f_l2_we;
    logic [7:0] f_rd_index, f_l2_index;
    logic [20:0] f_rd_tag, f_l2_tag;
    logic [1:0] f_rd_thread, f_l2_thread;
    logic [3:0] f_l2_way;
    logic f_init_busy, f_rd_valid, f_hit, f_victim_dirty, f_core_ready;
    logic [3:0] f_hit_way, f_victim_way;
    logic [20:0] f_victim_tag;
    logic [1:0] f_victim_thread;

    int checks = 0;
    int errors = 0;

    dtag_array_nway dut (
        .clk(clk), .rst(rst), .init_busy(init_busy),
        .rd_en(rd_en), .rd_index(rd_index), .rd_tag(rd_tag), .rd_thread(rd_thread),
        .rd_valid(rd_valid), .hit(hit), .hit_way(hit_way), .victim_way(victim_way),
        .victim_tag(victim_tag), .victim_dirty(victim_dirty), .victim_thread(victim_thread),
        .l2_we(l2_we), .l2_index(l2_index), .l2_way(l2_way), .l2_tag(l2_tag), .l2_thread(l2_thread),
        .mem_we(mem_we), .mem_index(mem_index), .mem_way(mem_way), .mem_tag(mem_tag), .mem_thread(mem_thread),
        .core_we(core_we), .core_index(core_index), .core_way(core_way), .core_ready(core_ready)
    );

    dtag_array_nway #(.WAYS(4)) dut4 (
        .clk(clk), .rst(rst), .init_busy(f_init_busy),
        .rd_en(f_rd_en), .rd_index(f_rd_index), .rd_tag(f_rd_tag), .rd_thread(f_rd_thread),
        .rd_valid(f_rd_valid), .hit(f_hit), .hit_way(f_hit_way), .victim_way(f_victim_way),
        .victim_tag(f_victim_tag), .victim_dirty(f_victim_dirty), .victim_thread(f_victim_thread),
        .l2_we(f_l2_we), .l2_index(f_l2_index), .l2_way(f_l2_way), .l2_tag(f_l2_tag), .l2_thread(f_l2_thread),
        .mem_we(1'b0), .mem_index(8'd0), .mem_way(4'd0), .mem_tag(21'd0), .mem_thread(2'd0),
        .core_we(1'b0), .core_index(8'd0), .core_way(4'd0), .core_ready(f_core_ready)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [7:0] idx, input logic [20:0] tag, input logic [1:0] thr);
        rd_en = 1'b1; rd_index = idx; rd_tag = tag; rd_thread = thr;
        tick;
        rd_en = 1'b0;
    endtask

    task automatic l2_write(input logic [7:0] idx, input logic [1:0] way, input logic [20:0] tag, input logic [1:0] thr);
        l2_we = 1'b1; l2_index = idx; l2_way = way; l2_tag = tag; l2_thread = thr;
        tick;
        l2_we = 1'b0;
    endtask

    task automatic count_sweep(output int n, output logic bad);
        n = 0;
        bad = 1'b0;
        while (init_busy && n < 1000) begin
            if (rd_valid || core_ready) bad = 1'b1;
            tick;
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        {rd_en, l2_we, mem_we, core_we, f_rd_en, f_l2_we} = '0;
        {rd_index, rd_tag, rd_thread, l2_index, l2_way, l2_tag, l2_thread} = '0;
        {mem_index, mem_way, mem_tag, mem_thread, core_index, core_way} = '0;
        {f_rd_index, f_rd_tag, f_rd_thread, f_l2_index, f_l2_way, f_l2_tag, f_l2_thread} = '0;
        tick;
        tick;
        checks++;
        if (init_busy !== 1'b1) begin errors++; $display("FAIL reset_init_busy got %b exp 1", init_busy); end
        checks++;
        if ({rd_valid, hit, hit_way, victim_way, victim_tag, victim_dirty, victim_thread, core_ready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", {rd_valid, hit, hit_way, victim_way, victim_tag, victim_dirty, victim_thread, core_ready});
        end
    endtask

    task automatic test_init_sweep;
        int n;
        logic bad;
        rst = 1'b0;
        rd_en = 1'b1; rd_index = 8'd0;
        core_we = 1'b1; core_index = 8'd3; core_way = 2'b01;
        count_sweep(n, bad);
        rd_en = 1'b0;
        core_we = 1'b0;
        checks++;
        if (n !== 256) begin errors++; $display("FAIL sweep_cycles got %0d exp 256", n); end
        checks++;
        if (bad !== 1'b0) begin errors++; $display("FAIL sweep_quiet got %b exp 0", bad); end
        checks++;
        if (f_init_busy !== 1'b0) begin errors++; $display("FAIL sweep_4way_done got %b exp 0", f_init_busy); end
        tick;
        checks++;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL init_rd_ignored got %b exp 0", rd_valid); end
        checks++;
        if (victim_way !== 2'b00) begin errors++; $display("FAIL no_lookup_victim got %b exp 00", victim_way); end
    endtask

    task automatic test_refill_hit;
        l2_write(8'd5, 2'b01, 21'h1ABCD, 2'd2);
        lookup(8'd5, 21'h1ABCD, 2'd2);
        checks++;
        if (rd_valid !== 1'b1) begin errors++; $display("FAIL hit_rd_valid got %b exp 1", rd_valid); end
        checks++;
        if ({hit, hit_way} !== 3'b101) begin errors++; $display("FAIL hit_way5 got %b exp 101", {hit, hit_way}); end
        tick;
        checks++;
        if ({rd_valid, hit} !== 2'b01) begin errors++; $display("FAIL hit_hold got %b exp 01", {rd_valid, hit}); end
        lookup(8'd5, 21'h1ABCD, 2'd1);
        checks++;
        if ({hit, hit_way} !== 3'b000) begin errors++; $display("FAIL thread_miss got %b exp 000", {hit, hit_way}); end
        checks++;
        if ({victim_way, victim_dirty} !== 3'b100) begin errors++; $display("FAIL invalid_victim got %b exp 100", {victim_way, victim_dirty}); end
    endtask

    task automatic test_core_arb;
        core_we = 1'b1; core_index = 8'd5; core_way = 2'b01;
        l2_we = 1'b1; l2_index = 8'd9; l2_way = 2'b01; l2_tag = 21'h00042; l2_thread = 2'd0;
        #1;
        checks++;
        if (core_ready !== 1'b0) begin errors++; $display("FAIL core_blocked got %b exp 0", core_ready); end
        tick;
        l2_we = 1'b0;
        #1;
        checks++;
        if (core_ready !== 1'b1) begin errors++; $display("FAIL core_accept got %b exp 1", core_ready); end
        tick;
        core_we = 1'b0;
        l2_write(8'd5, 2'b10, 21'h0F0F0, 2'd1);
        lookup(8'd5, 21'h12345, 2'd0);
        checks++;
        if ({hit, hit_way} !== 3'b000) begin errors++; $display("FAIL set5_miss got %b exp 000", {hit, hit_way}); end
        checks++;
        if ({victim_way, victim_dirty} !== 3'b011) begin errors++; $display("FAIL dirty_victim got %b exp 011", {victim_way, victim_dirty}); end
        checks++;
        if ({victim_tag, victim_thread} !== {21'h1ABCD, 2'd2}) begin
            errors++; $display("FAIL victim_tag got %h/%0d exp 1abcd/2", victim_tag, victim_thread);
        end
        lookup(8'd9, 21'h00042, 2'd0);
        checks++;
        if (hit_way !== 2'b01) begin errors++; $display("FAIL l2_won_set9 got %b exp 01", hit_way); end
    endtask

    task automatic test_write_first;
        mem_we = 1'b1; mem_index = 8'd7; mem_way = 2'b10; mem_tag = 21'h00777; mem_thread = 2'd3;
        rd_en = 1'b1; rd_index = 8'd7; rd_tag = 21'h00777; rd_thread = 2'd3;
        tick;
        mem_we = 1'b0;
        rd_en = 1'b0;
        checks++;
        if ({rd_valid, hit, hit_way} !== 4'b1110) begin errors++; $display("FAIL write_first got %b exp 1110", {rd_valid, hit, hit_way}); end
    endtask

    task automatic test_refill_clears_dirty;
        l2_write(8'd5, 2'b01, 21'h00001, 2'd0);
        l2_write(8'd5, 2'b10, 21'h00002, 2'd0);
        lookup(8'd5, 21'h00003, 2'd0);
        checks++;
        if (victim_way !== 2'b01) begin errors++; $display("FAIL refill_victim got %b exp 01", victim_way); end
        checks++;
        if ({victim_tag, victim_dirty} !== {21'h00001, 1'b0}) begin
            errors++; $display("FAIL refill_clean got %h/%b exp 00001/0", victim_tag, victim_dirty);
        end
    endtask

    task automatic test_repl_4way;
        logic [3:0] exp_v;
`ifdef DTAG_PLRU_EN
        exp_v = 4'b0100;
`else
        exp_v = 4'b0001;
`endif
        for (int i = 0; i < 4; i++) begin
            f_l2_we = 1'b1; f_l2_index = 8'd2; f_l2_way = 4'b0001 << i; f_l2_tag = 21'h10 + 21'(i); f_l2_thread = 2'd0;
            tick;
        end
        f_l2_we = 1'b0;
        f_rd_en = 1'b1; f_rd_index = 8'd2; f_rd_tag = 21'h10; f_rd_thread = 2'd0;
        tick;
        f_rd_en = 1'b0;
        checks++;
        if (f_hit_way !== 4'b0001) begin errors++; $display("FAIL way4_hit got %b exp 0001", f_hit_way); end
        tick;
        f_rd_en = 1'b1; f_rd_tag = 21'h99;
        tick;
        f_rd_en = 1'b0;
        checks++;
        if (f_victim_way !== exp_v) begin errors++; $display("FAIL way4_victim got %b exp %b", f_victim_way, exp_v); end
        checks++;
        if ({f_hit, f_victim_dirty} !== 2'b00) begin errors++; $display("FAIL way4_miss got %b exp 00", {f_hit, f_victim_dirty}); end
    endtask

    task automatic test_reset_mid_sweep;
        int n;
        logic bad;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        repeat (100) tick;
        rst = 1'b1;
        tick;
        checks++;
        if ({init_busy, rd_valid, victim_way} !== 4'b1000) begin
            errors++; $display("FAIL midsweep_reset got %b exp 1000", {init_busy, rd_valid, victim_way});
        end
        tick;
        rst = 1'b0;
        count_sweep(n, bad);
        checks++;
        if (n !== 256) begin errors++; $display("FAIL restart_cycles got %0d exp 256", n); end
        lookup(8'd9, 21'h00042, 2'd0);
        checks++;
        if ({hit, victim_way} !== 3'b001) begin errors++; $display("FAIL swept_set9 got %b exp 001", {hit, victim_way}); end
    endtask

    initial begin
        test_reset;
        test_init_sweep;
        test_refill_hit;
        test_core_arb;
        test_write_first;
        test_refill_clears_dirty;
        test_repl_4way;
        test_reset_mid_sweep;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
